// File: rtl/userio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : userio_pkg
// Purpose  : Shared constants, FSM state type and helpers for the scroll-wheel
//            to Amiga raw-key translator (userio_wheelkeys).
// Contents : KEY_WHEEL_UP / KEY_WHEEL_DOWN raw-key codes, KEY_RELEASE_BIT,
//            wk_state_t (IDLE, PRESS, RELEASE, GAP), release_code().
// Revision : 1.0 - initial release
// ============================================================================
package userio_pkg;

    localparam logic [7:0] KEY_WHEEL_UP    = 8'h7A;
    localparam logic [7:0] KEY_WHEEL_DOWN  = 8'h7B;
    localparam int         KEY_RELEASE_BIT = 7;

    // GAP is only reachable when the pacing build option is enabled.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2,
        GAP     = 2'd3
    } wk_state_t;

    // Amiga raw-key release codes are the press code with bit 7 set.
    function automatic logic [7:0] release_code(input logic [7:0] code);
        logic [7:0] rc;
        rc                  = code;
        rc[KEY_RELEASE_BIT] = 1'b1;
        return rc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/userio_wheel_acc.sv
`default_nettype none
// ============================================================================
// Module   : userio_wheel_acc
// Purpose  : Tracks the mouse Z counter and keeps a saturating signed count of
//            wheel detents that still have to be turned into key events.
// Ports    : clk, reset         - 28 MHz clock, synchronous active-high reset
//            clk7_en            - 7 MHz enable qualifying every update
//            sof                - start-of-frame strobe (Z sampling point)
//            zcount[7:0]        - wrapping two's-complement Z counter
//            enable             - translation enable; clears the count when 0
//            launch_up/_dn      - one detent consumed by the event FSM
//            pend_up / pend_dn  - count is positive / negative (and enabled)
// Revision : 1.0 - initial release
// ============================================================================
module userio_wheel_acc #(
    parameter int PEND_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic       sof,
    input  logic [7:0] zcount,
    input  logic       enable,
    input  logic       launch_up,
    input  logic       launch_dn,
    output logic       pend_up,
    output logic       pend_dn
);

    // Pending count needs a sign bit plus enough magnitude for PEND_MAX.
    localparam int PW = $clog2(PEND_MAX + 1) + 1;
    // Sum width covers pending + a full signed 8-bit delta + the launch term.
    localparam int SW = PW + 10;

    localparam logic signed [PW-1:0] PMAX_P = PW'(PEND_MAX);
    localparam logic signed [PW-1:0] PMAX_N = -PW'(PEND_MAX);
    localparam logic signed [SW-1:0] SMAX_P = SW'(PEND_MAX);
    localparam logic signed [SW-1:0] SMAX_N = -SW'(PEND_MAX);

    logic        [7:0]    last_z_q, last_z_d;
    logic signed [PW-1:0] pending_q, pending_d;
    logic signed [7:0]    delta;
    logic signed [SW-1:0] delta_ext;
    logic signed [SW-1:0] launch_ext;
    logic signed [SW-1:0] sum;
    logic                 sample;

    always_comb begin
        sample = clk7_en & sof;

        // Wrapping 8-bit subtraction: 0x7F -> 0x80 and 0xFE -> 0x02 both come
        // out as small positive steps when read as signed.
        delta     = $signed(zcount - last_z_q);
        delta_ext = sample ? {{(SW-8){delta[7]}}, delta} : '0;

        if (launch_up) begin
            launch_ext = SW'(1);
        end else if (launch_dn) begin
            launch_ext = {SW{1'b1}};
        end else begin
            launch_ext = '0;
        end

        sum = {{(SW-PW){pending_q[PW-1]}}, pending_q} + delta_ext - launch_ext;

        // Z position is tracked even while disabled so re-enabling does not
        // replay old movement.
        last_z_d = sample ? zcount : last_z_q;

        pending_d = pending_q;
        if (clk7_en) begin
            if (!enable) begin
                pending_d = '0;
            end else if (sum > SMAX_P) begin
                pending_d = PMAX_P;
            end else if (sum < SMAX_N) begin
                pending_d = PMAX_N;
            end else begin
                pending_d = $signed(sum[PW-1:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_z_q  <= 8'h00;
            pending_q <= '0;
        end else begin
            last_z_q  <= last_z_d;
            pending_q <= pending_d;
        end
    end

    // Gating with enable makes the forced clear visible to the FSM in the
    // same cycle enable drops, so no new press starts once disabled.
    assign pend_up = enable & ~pending_q[PW-1] & (pending_q != '0);
    assign pend_dn = enable &  pending_q[PW-1];

endmodule
`default_nettype wire

// File: rtl/userio_wheelkeys.sv
`default_nettype none
// ============================================================================
// Module   : userio_wheelkeys
// Purpose  : Turns PS/2 scroll-wheel movement (Z counter) into Amiga raw-key
//            press/release pairs (0x7A/0xFA up, 0x7B/0xFB down) delivered one
//            byte at a time over a valid/ready handshake.
// Ports    : clk, reset         - 28 MHz clock, synchronous active-high reset
//            clk7_en            - 7 MHz enable qualifying state and handshake
//            sof                - start-of-frame strobe
//            zcount[7:0]        - mouse Z counter
//            enable             - wheel-to-key translation enable
//            key_data[7:0]      - raw-key code, stable while key_valid
//            key_valid          - key_data holds a byte for the consumer
//            key_ready          - consumer accepts the byte
// Build    : USERIO_WHEEL_PACE_EN - when defined, GAP_FRAMES start-of-frame
//            strobes are waited out after every release before the next press.
// Revision : 1.0 - initial release
// ============================================================================
module userio_wheelkeys
    import userio_pkg::*;
#(
    parameter int PEND_MAX   = 15,
    parameter int GAP_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic       sof,
    input  logic [7:0] zcount,
    input  logic       enable,
    output logic [7:0] key_data,
    output logic       key_valid,
    input  logic       key_ready
);

    localparam int GW = ($clog2(GAP_FRAMES + 1) > 0) ? $clog2(GAP_FRAMES + 1) : 1;

    wk_state_t     state_q, state_d;
    logic [7:0]    key_data_q, key_data_d;
    logic          key_valid_q, key_valid_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    logic          pend_up, pend_dn;
    logic          launch_up, launch_dn;
    logic          xfer;

    userio_wheel_acc #(
        .PEND_MAX (PEND_MAX)
    ) u_acc (
        .clk       (clk),
        .reset     (reset),
        .clk7_en   (clk7_en),
        .sof       (sof),
        .zcount    (zcount),
        .enable    (enable),
        .launch_up (launch_up),
        .launch_dn (launch_dn),
        .pend_up   (pend_up),
        .pend_dn   (pend_dn)
    );

    always_comb begin
        state_d     = state_q;
        key_data_d  = key_data_q;
        key_valid_d = key_valid_q;
        gap_cnt_d   = gap_cnt_q;
        launch_up   = 1'b0;
        launch_dn   = 1'b0;

        xfer = clk7_en & key_valid_q & key_ready;

        if (clk7_en) begin
            case (state_q)
                IDLE: begin
                    // A launch consumes one detent from the accumulator in the
                    // same cycle, so the pair is accounted for exactly once.
                    if (pend_up) begin
                        key_data_d  = KEY_WHEEL_UP;
                        key_valid_d = 1'b1;
                        launch_up   = 1'b1;
                        state_d     = PRESS;
                    end else if (pend_dn) begin
                        key_data_d  = KEY_WHEEL_DOWN;
                        key_valid_d = 1'b1;
                        launch_dn   = 1'b1;
                        state_d     = PRESS;
                    end
                end

                PRESS: begin
                    // key_valid stays high: the release follows directly and
                    // is sent even if enable has dropped meanwhile.
                    if (xfer) begin
                        key_data_d = release_code(key_data_q);
                        state_d    = RELEASE;
                    end
                end

                RELEASE: begin
                    if (xfer) begin
                        key_valid_d = 1'b0;
`ifdef USERIO_WHEEL_PACE_EN
                        if (GAP_FRAMES == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end

                GAP: begin
                    if (sof) begin
                        if (gap_cnt_q == GW'(GAP_FRAMES - 1)) begin
                            state_d = IDLE;
                        end else begin
                            gap_cnt_d = gap_cnt_q + GW'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            key_data_q  <= 8'h00;
            key_valid_q <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;

endmodule
`default_nettype wire
